// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  // Multiply/divide family occupies the lower half of the op space.
  function automatic logic is_iter_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to apply the sign fix-up to products, quotients and remainders.
module cond_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO moves.
// Handshake: start is taken only while busy=0; done pulses once when hi/lo are updated.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   a_orig;
  logic               is_div, neg_res, neg_rem, div_zero;

  logic               idle, go, mv_hi, mv_lo;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign idle  = (state == S_IDLE);
  assign go    = start && idle && is_iter_op(op);
  assign mv_hi = start && idle && (op == OP_MTHI);
  assign mv_lo = start && idle && (op == OP_MTLO);
  assign busy  = !idle;

  assign neg_a = is_signed_op(op) && a[WIDTH-1];
  assign neg_b = is_signed_op(op) && b[WIDTH-1];

  cond_neg #(.W(WIDTH)) u_abs_a (.neg(neg_a), .x(a), .y(a_mag));
  cond_neg #(.W(WIDTH)) u_abs_b (.neg(neg_b), .x(b), .y(b_mag));

  // Shift-add multiply: low half holds the remaining multiplier bits, the
  // upper half accumulates partial sums with a carry bit that shifts in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, low half shifts
  // dividend bits out and quotient bits in.
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, opd};
  assign div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

  cond_neg #(.W(2*WIDTH)) u_fix_prod (.neg(neg_res), .x(acc),                     .y(prod_fix));
  cond_neg #(.W(WIDTH))   u_fix_quot (.neg(neg_res), .x(acc[WIDTH-1:0]),          .y(quot_fix));
  cond_neg #(.W(WIDTH))   u_fix_rem  (.neg(neg_rem), .x(acc[2*WIDTH-1:WIDTH]),    .y(rem_fix));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (go) state_nxt = S_RUN;
      S_RUN:   if (cnt == CNT_MAX) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      a_orig   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            cnt      <= '0;
            is_div   <= is_div_op(op);
            neg_res  <= neg_a ^ neg_b;
            neg_rem  <= neg_a;
            div_zero <= (b == '0);
            a_orig   <= a;
            if (is_div_op(op)) begin
              acc <= {{WIDTH{1'b0}}, a_mag};
              opd <= b_mag;
            end else begin
              acc <= {{WIDTH{1'b0}}, b_mag};
              opd <= a_mag;
            end
          end else if (mv_hi) begin
            hi   <= a;
            done <= 1'b1;
          end else if (mv_lo) begin
            lo   <= a;
            done <= 1'b1;
          end
        end
        S_RUN: begin
          cnt <= cnt + CNT_W'(1);
          acc <= is_div ? div_step : mul_step;
        end
        S_FIN: begin
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero) begin
            // Divide by zero returns the raw dividend, not its magnitude.
            hi <= a_orig;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8 with a done-driven
// scoreboard; expected {hi,lo} pairs are queued when each operation is issued.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, rst8;
  logic        start32, start8;
  logic [2:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, busy8, done8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q32[$];
  logic [15:0] exp_q8[$];
  logic [31:0] mhi[2];
  logic [31:0] mlo[2];
  logic [63:0] e32;
  logic [15:0] e8;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (exp_q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL done32: pulse seen with no operation pending (t=%0t)", $time);
      end else begin
        e32 = exp_q32.pop_front();
        chk("result32 {hi,lo}", {hi32, lo32}, e32);
      end
    end
    if (done8 === 1'b1) begin
      if (exp_q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8: pulse seen with no operation pending (t=%0t)", $time);
      end else begin
        e8 = exp_q8.pop_front();
        chk("result8 {hi,lo}", {48'h0, hi8, lo8}, {48'h0, e8});
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [31:0] msk(input int sel, input logic [31:0] v);
    return sel ? {24'h0, v[7:0]} : v;
  endfunction

  function automatic logic get_busy(input int sel);
    return sel ? busy8 : busy32;
  endfunction

  function automatic logic get_done(input int sel);
    return sel ? done8 : done32;
  endfunction

  function automatic logic [63:0] get_hilo(input int sel);
    return sel ? {24'h0, hi8, 24'h0, lo8} : {hi32, lo32};
  endfunction

  task automatic drive(input int sel, input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel != 0) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; op32 = op; a32 = a; b32 = b;
    end
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel != 0) rst8 = v;
    else          rst32 = v;
  endtask

  task automatic push_exp(input int sel, input logic [31:0] h, input logic [31:0] l);
    mhi[sel] = msk(sel, h);
    mlo[sel] = msk(sel, l);
    if (sel != 0) exp_q8.push_back({h[7:0], l[7:0]});
    else          exp_q32.push_back({h, l});
  endtask

  task automatic wait_idle(input int sel, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!get_busy(sel)) return;
      n++;
    end
    checks++; errors++;
    $display("FAIL busy timeout sel=%0d: still busy after 200 cycles, required idle", sel);
  endtask

  task automatic run_op(input int sel, input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    int w;
    w = (sel != 0) ? 8 : 32;
    push_exp(sel, eh, el);
    drive(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, op, a, b);
    wait_idle(sel, n);
    chk({name, " busy cycles"}, 64'(n), 64'(w + 1));
  endtask

  task automatic run_move(input int sel, input logic to_lo, input logic [31:0] a);
    logic [31:0] h, l;
    h = to_lo ? mhi[sel] : msk(sel, a);
    l = to_lo ? msk(sel, a) : mlo[sel];
    push_exp(sel, h, l);
    drive(sel, 1'b1, to_lo ? OP_MTLO : OP_MTHI, a, 32'h0);
    @(posedge clk); #1;
    drive(sel, 1'b0, 3'b000, 32'h0, 32'h0);
    chk(to_lo ? "mtlo {hi,lo}" : "mthi {hi,lo}", get_hilo(sel), {h, l});
    chk("move busy", 64'(get_busy(sel)), 64'(0));
    chk("move done", 64'(get_done(sel)), 64'(1));
    @(posedge clk); #1;
    chk("move done width", 64'(get_done(sel)), 64'(0));
  endtask

  // ---------------- stimulus plan ----------------
  task automatic run_plan(input int sel);
    int w, n, rc;
    logic [31:0] mn;
    w  = (sel != 0) ? 8 : 32;
    mn = (sel != 0) ? 32'h0000_0080 : 32'h8000_0000;

    run_op(sel, "mult -3*7",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(sel, "multu max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    // Issued from the done cycle of the previous op.
    run_op(sel, "divu 100/0", OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op(sel, "div -7/2",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(sel, "div mn/-1",  OP_DIV,   mn,            32'hFFFF_FFFF, 32'h0000_0000, mn);

    run_move(sel, 1'b0, 32'h1234_5678);
    run_move(sel, 1'b1, 32'hCAFE_F00D);

    // Unused op code: no state change and no done pulse.
    drive(sel, 1'b1, 3'b110, 32'hDEAD_BEEF, 32'h1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("unused op busy", 64'(get_busy(sel)), 64'(0));
    repeat (3) @(negedge clk);
    chk("unused op {hi,lo}", get_hilo(sel), {mhi[sel], mlo[sel]});

    // Start while busy must be ignored.
    push_exp(sel, 32'h0000_0002, 32'h0000_000E);
    drive(sel, 1'b1, OP_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(sel, 1'b0, OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 drive(sel, 1'b1, OP_MULT, 32'd2, 32'd3);
    @(posedge clk); #1;
    drive(sel, 1'b0, OP_MULT, 32'd2, 32'd3);
    wait_idle(sel, n);
    chk("ignored start busy tail", 64'(n), 64'(w - 4));
    repeat (w + 5) @(negedge clk);

    // Asynchronous reset mid-operation.
    rc = (sel != 0) ? 4 : 10;
    drive(sel, 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(sel, 1'b0, OP_MULTU, 32'h0, 32'h0);
    repeat (rc - 1) @(posedge clk);
    #3 set_rst(sel, 1'b1);
    #1;
    chk("async reset busy", 64'(get_busy(sel)), 64'(0));
    chk("async reset done", 64'(get_done(sel)), 64'(0));
    chk("async reset {hi,lo}", get_hilo(sel), 64'h0);
    mhi[sel] = 32'h0;
    mlo[sel] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) set_rst(sel, 1'b0);
    repeat (w + 5) @(negedge clk);
    chk("post-reset {hi,lo}", get_hilo(sel), 64'h0);

    run_op(sel, "multu 6*7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'h0000_002A);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst32 = 1'b1;
    rst8  = 1'b1;
    drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
    mhi[0] = 32'h0; mlo[0] = 32'h0;
    mhi[1] = 32'h0; mlo[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy32", 64'(busy32), 64'(0));
    chk("reset done32", 64'(done32), 64'(0));
    chk("reset hilo32", get_hilo(0), 64'h0);
    chk("reset busy8",  64'(busy8), 64'(0));
    chk("reset hilo8",  get_hilo(1), 64'h0);
    @(negedge clk);
    rst32 = 1'b0;
    rst8  = 1'b0;
    @(negedge clk);

    run_plan(0);
    run_plan(1);

    @(negedge clk);
    chk("queue32 drained", 64'(exp_q32.size()), 64'(0));
    chk("queue8 drained",  64'(exp_q8.size()),  64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
